dec3_8_scan: RTL and testbench

//  3-to-8 decoder, the reverse of the board's 8-to-3 priority encoder path.

---
 rtl/dec3_8_scan_pkg.sv | 17 +
 rtl/bcd7seg.sv | 25 ++
 rtl/dec3_8_scan_tick_gen.sv | 33 +++
 rtl/dec3_8_scan.sv | 102 ++++++++++
 tb/tb_dec3_8_scan.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dec3_8_scan_pkg.sv
// Shared types for the 3-to-8 scan decoder: FSM states,
// the blank 7-seg pattern and the one-hot helper.
package dec3_8_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7f;

    function automatic logic [7:0] onehot8(input logic [2:0] c);
        return 8'h01 << c;
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// BCD to 7-segment decoder, active-low segments {g,f,e,d,c,b,a}.
// Ports: b (4-bit digit) -> h (7 segments, 7'h7f blank).
module bcd7seg (
    input  logic [3:0] b,
    output logic [6:0] h
);

    always_comb begin
        h = 7'h7f;
        case (b)
            4'd0: h = 7'h40;
            4'd1: h = 7'h79;
            4'd2: h = 7'h24;
            4'd3: h = 7'h30;
            4'd4: h = 7'h19;
            4'd5: h = 7'h12;
            4'd6: h = 7'h02;
            4'd7: h = 7'h78;
            4'd8: h = 7'h00;
            4'd9: h = 7'h10;
            default: h = 7'h7f;
        endcase
    end

endmodule

// File: rtl/dec3_8_scan_tick_gen.sv
// Scan prescaler: counts 0..TICK_DIV-1 while run is high.
// Ports: clk, rst (async active-low), run, clr -> tick.
module tick_gen
    import dec3_8_scan_pkg::*;
#(
    parameter int DIV_W    = 23,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    // A clear wins over the terminal count, so no step fires then.
    assign tick = run && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!run || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/dec3_8_scan.sv
// 3-to-8 decoder with manual hold and prescaled auto-scan.
// Ports: clk, rst (async active-low), code_i, valid_i, mode_i;
//   O (registered one-hot), code_o, act_o, tick_o,
//   h (7-seg of code_o, only when DEC_SEG_EN is defined).
module dec3_8_scan
    import dec3_8_scan_pkg::*;
#(
    parameter int TICK_DIV = 5_000_000,
    parameter int DIV_W    = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_i,
    input  logic       valid_i,
    input  logic       mode_i,
    output logic [7:0] O,
    output logic [2:0] code_o,
    output logic       act_o,
    output logic       tick_o
`ifdef DEC_SEG_EN
    ,
    output logic [6:0] h
`endif
);

    state_t st;
    logic   run;
    logic   clr;
    logic   tick;

    // Prescaler restarts on any load or when scanning is dropped.
    assign run = (st == ST_SCAN);
    assign clr = valid_i | ~mode_i;

    tick_gen #(
        .DIV_W    (DIV_W),
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st     <= ST_IDLE;
            code_o <= 3'd0;
            O      <= 8'h00;
            act_o  <= 1'b0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (valid_i) begin
                        code_o <= code_i;
                        O      <= onehot8(code_i);
                        act_o  <= 1'b1;
                        st     <= mode_i ? ST_SCAN : ST_HOLD;
                    end else if (mode_i) begin
                        code_o <= 3'd0;
                        O      <= 8'h01;
                        act_o  <= 1'b1;
                        st     <= ST_SCAN;
                    end
                end
                ST_HOLD, ST_SCAN: begin
                    st <= mode_i ? ST_SCAN : ST_HOLD;
                    // A load takes priority over a pending step.
                    if (valid_i) begin
                        code_o <= code_i;
                        O      <= onehot8(code_i);
                    end else if (tick) begin
                        code_o <= code_o + 3'd1;
                        O      <= onehot8(code_o + 3'd1);
                        tick_o <= 1'b1;
                    end
                end
                default: begin
                    st     <= ST_IDLE;
                    code_o <= 3'd0;
                    O      <= 8'h00;
                    act_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEC_SEG_EN
    logic [6:0] seg;

    bcd7seg u_seg (
        .b ({1'b0, code_o}),
        .h (seg)
    );

    assign h = (st == ST_IDLE) ? SEG_BLANK : seg;
`endif

endmodule

// File: tb/tb_dec3_8_scan.sv
// Directed bench for dec3_8_scan (TICK_DIV=4) with a
// scoreboard of expected output bundles.
module tb_dec3_8_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] code_i = 3'd0;
    logic       valid_i = 1'b0;
    logic       mode_i = 1'b0;
    logic [7:0] O;
    logic [2:0] code_o;
    logic       act_o;
    logic       tick_o;
`ifdef DEC_SEG_EN
    logic [6:0] h;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] o;
        logic [2:0] c;
        logic       a;
        logic       t;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dec3_8_scan #(
        .TICK_DIV (4),
        .DIV_W    (23)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .code_i  (code_i),
        .valid_i (valid_i),
        .mode_i  (mode_i),
        .O       (O),
        .code_o  (code_o),
        .act_o   (act_o),
        .tick_o  (tick_o)
`ifdef DEC_SEG_EN
        ,
        .h       (h)
`endif
    );

    function automatic logic [6:0] seg_ref(input logic [2:0] c);
        case (c)
            3'd0: return 7'h40;
            3'd1: return 7'h79;
            3'd2: return 7'h24;
            3'd3: return 7'h30;
            3'd4: return 7'h19;
            3'd5: return 7'h12;
            3'd6: return 7'h02;
            default: return 7'h78;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s observed empty scoreboard expected entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".O"}, O, e.o);
        chk({tag, ".code"}, {5'b0, code_o}, {5'b0, e.c});
        chk({tag, ".act"}, {7'b0, act_o}, {7'b0, e.a});
        chk({tag, ".tick"}, {7'b0, tick_o}, {7'b0, e.t});
`ifdef DEC_SEG_EN
        chk({tag, ".h"}, {1'b0, h},
            {1'b0, (e.a ? seg_ref(e.c) : 7'h7f)});
`endif
    endtask

    task automatic expect_edge(input logic [7:0] o, input logic [2:0] c,
                               input logic a, input logic t,
                               input string tag);
        exp_t e;
        e = {o, c, a, t};
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic expect_now(input logic [7:0] o, input logic [2:0] c,
                              input logic a, input logic t,
                              input string tag);
        exp_t e;
        e = {o, c, a, t};
        sb.push_back(e);
        compare(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset held low
        expect_edge(8'h00, 3'd0, 1'b0, 1'b0, "reset0");
        expect_edge(8'h00, 3'd0, 1'b0, 1'b0, "reset1");
        rst = 1'b1;
        expect_edge(8'h00, 3'd0, 1'b0, 1'b0, "idle");

        // Manual load of 5, then hold with valid low
        code_i = 3'd5;
        valid_i = 1'b1;
        expect_edge(8'h20, 3'd5, 1'b1, 1'b0, "load5");
        valid_i = 1'b0;
        code_i = 3'd1;
        repeat (3) expect_edge(8'h20, 3'd5, 1'b1, 1'b0, "hold5");

        // Asynchronous reset from HOLD
        rst = 1'b0;
        #2;
        expect_now(8'h00, 3'd0, 1'b0, 1'b0, "async_rst_hold");
        expect_edge(8'h00, 3'd0, 1'b0, 1'b0, "rst_edge");

        // Scan from IDLE: 4 cycles per step, wraps 7 -> 0
        rst = 1'b1;
        mode_i = 1'b1;
        for (int n = 0; n <= 44; n++) begin
            int k;
            k = n / 4;
            expect_edge(8'h01 << (k % 8), 3'(k % 8), 1'b1,
                        (n % 4 == 0) && (k > 0), "scan");
        end

        // Drop scan at code 3: holds, no ticks
        mode_i = 1'b0;
        repeat (20) expect_edge(8'h08, 3'd3, 1'b1, 1'b0, "stop");

        // Resume scan from current code, load 2 mid-step
        mode_i = 1'b1;
        repeat (3) expect_edge(8'h08, 3'd3, 1'b1, 1'b0, "resume");
        code_i = 3'd2;
        valid_i = 1'b1;
        expect_edge(8'h04, 3'd2, 1'b1, 1'b0, "load2");
        valid_i = 1'b0;
        repeat (3) expect_edge(8'h04, 3'd2, 1'b1, 1'b0, "load2_wait");
        expect_edge(8'h08, 3'd3, 1'b1, 1'b1, "step_after_load");

        // Load on the exact step cycle: load wins, no tick
        repeat (3) expect_edge(8'h08, 3'd3, 1'b1, 1'b0, "pre_step");
        code_i = 3'd6;
        valid_i = 1'b1;
        expect_edge(8'h40, 3'd6, 1'b1, 1'b0, "valid_beats_step");
        valid_i = 1'b0;
        repeat (3) expect_edge(8'h40, 3'd6, 1'b1, 1'b0, "load6_wait");
        expect_edge(8'h80, 3'd7, 1'b1, 1'b1, "step7");

        // Same-cycle load and mode drop
        code_i = 3'd1;
        valid_i = 1'b1;
        mode_i = 1'b0;
        expect_edge(8'h02, 3'd1, 1'b1, 1'b0, "load_and_stop");
        valid_i = 1'b0;
        repeat (6) expect_edge(8'h02, 3'd1, 1'b1, 1'b0, "hold1");

        // HOLD -> SCAN from current code
        mode_i = 1'b1;
        repeat (4) expect_edge(8'h02, 3'd1, 1'b1, 1'b0, "scan_hold");
        expect_edge(8'h04, 3'd2, 1'b1, 1'b1, "scan_from_hold");
        repeat (2) expect_edge(8'h04, 3'd2, 1'b1, 1'b0, "scan_mid");

        // Asynchronous reset mid-scan
        rst = 1'b0;
        #2;
        expect_now(8'h00, 3'd0, 1'b0, 1'b0, "async_rst_scan");
        expect_edge(8'h00, 3'd0, 1'b0, 1'b0, "rst_scan_edge");
        rst = 1'b1;
        mode_i = 1'b0;
        repeat (3) expect_edge(8'h00, 3'd0, 1'b0, 1'b0, "idle_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
